// File: rtl/nibbler_pkg.sv
// Shared types and constants for the Nibbler control path: opcodes, sequencer
// states, ALU mode words and the decoded control word.
package nibbler_pkg;

    typedef enum logic [3:0] {
        OP_JC   = 4'h0, OP_JNC  = 4'h1, OP_CMPI = 4'h2, OP_CMPM = 4'h3,
        OP_LIT  = 4'h4, OP_IN   = 4'h5, OP_LD   = 4'h6, OP_ST   = 4'h7,
        OP_JZ   = 4'h8, OP_JNZ  = 4'h9, OP_ADDI = 4'hA, OP_ADDM = 4'hB,
        OP_JMP  = 4'hC, OP_OUT  = 4'hD, OP_NORI = 4'hE, OP_NORM = 4'hF
    } opcode_t;

    typedef enum logic [1:0] {
        FETCH   = 2'd0,
        FETCH2  = 2'd1,
        EXECUTE = 2'd2
    } state_t;

    // ALU mode words are {notCarryIn, aluS}.
    localparam logic [3:0] ALU_CMP  = 4'b0001;
    localparam logic [3:0] ALU_PASS = 4'b1010;
    localparam logic [3:0] ALU_ADD  = 4'b1011;
    localparam logic [3:0] ALU_NOR  = 4'b1100;

    // Bit n set when opcode n carries a second address byte.
    localparam logic [15:0] TWO_BYTE_MASK = 16'b1001_1011_1100_1011;

    typedef struct packed {
        logic [3:0] alu_mode;
        logic       not_oe_alu;
        logic       not_load_a;
        logic       not_oe_ram;
        logic       not_we_ram;
        logic       not_oe_in;
        logic       not_load_out;
        logic       operand_sel;
        logic       updates_flags;
        logic       is_jump;
        logic       two_byte;
    } ctrl_t;

    function automatic logic is_two_byte(input opcode_t op);
        return TWO_BYTE_MASK[op];
    endfunction

endpackage

// File: rtl/nibbler_control_if.sv
// Bus bundle between the Nibbler sequencer and ROM, RAM/IO and the ALU datapath,
// plus read-only debug taps of the sequencer state and flag registers.
interface nibbler_control_if #(parameter int ADDR_W = 12);
    import nibbler_pkg::*;

    // Timing contract: romData is combinational from romAddr within the same cycle;
    // every active-low strobe is high except during the single EXECUTE cycle that uses it.
    logic [ADDR_W-1:0] romAddr;
    logic [7:0]        romData;
    logic [3:0]        immediate;
    logic              operandSel;
    logic [ADDR_W-1:0] ramAddr;
    logic              notOeRam;
    logic              notWeRam;
    logic [2:0]        aluS;
    logic              notCarryIn;
    logic              notOeALU;
    logic              notLoadA;
    logic              notOeIn;
    logic              notLoadOut;
    logic              notC;
    logic              notZ;
    state_t            dbgState;
    logic              dbgCarry;
    logic              dbgZero;

    modport master (
        input  romData, notC, notZ,
        output romAddr, immediate, operandSel, ramAddr, notOeRam, notWeRam,
               aluS, notCarryIn, notOeALU, notLoadA, notOeIn, notLoadOut,
               dbgState, dbgCarry, dbgZero
    );

    modport slave (
        output romData, notC, notZ,
        input  romAddr, immediate, operandSel, ramAddr, notOeRam, notWeRam,
               aluS, notCarryIn, notOeALU, notLoadA, notOeIn, notLoadOut,
               dbgState, dbgCarry, dbgZero
    );

endinterface

// File: rtl/nibbler_decode.sv
// Combinational opcode decoder: produces the EXECUTE-cycle control word and
// the instruction-length bit for one opcode.
module nibbler_decode
    import nibbler_pkg::*;
(
    input  opcode_t op_i,
    output ctrl_t   ctrl_o
);

    always_comb begin
        ctrl_o               = '0;
        ctrl_o.alu_mode      = ALU_PASS;
        ctrl_o.not_oe_alu    = 1'b1;
        ctrl_o.not_load_a    = 1'b1;
        ctrl_o.not_oe_ram    = 1'b1;
        ctrl_o.not_we_ram    = 1'b1;
        ctrl_o.not_oe_in     = 1'b1;
        ctrl_o.not_load_out  = 1'b1;
        ctrl_o.two_byte      = is_two_byte(op_i);

        case (op_i)
            OP_CMPI, OP_CMPM: begin
                // Compare drives the ALU for its flags only; A keeps its value.
                ctrl_o.alu_mode      = ALU_CMP;
                ctrl_o.not_oe_alu    = 1'b0;
                ctrl_o.updates_flags = 1'b1;
            end
            OP_LIT, OP_LD: begin
                ctrl_o.not_oe_alu = 1'b0;
                ctrl_o.not_load_a = 1'b0;
            end
            OP_IN: begin
                ctrl_o.not_oe_alu = 1'b0;
                ctrl_o.not_load_a = 1'b0;
                ctrl_o.not_oe_in  = 1'b0;
            end
            OP_ADDI, OP_ADDM: begin
                ctrl_o.alu_mode      = ALU_ADD;
                ctrl_o.not_oe_alu    = 1'b0;
                ctrl_o.not_load_a    = 1'b0;
                ctrl_o.updates_flags = 1'b1;
            end
            OP_NORI, OP_NORM: begin
                ctrl_o.alu_mode      = ALU_NOR;
                ctrl_o.not_oe_alu    = 1'b0;
                ctrl_o.not_load_a    = 1'b0;
                ctrl_o.updates_flags = 1'b1;
            end
            OP_ST:  ctrl_o.not_we_ram   = 1'b0;
            OP_OUT: ctrl_o.not_load_out = 1'b0;
            OP_JC, OP_JNC, OP_JZ, OP_JNZ, OP_JMP: ctrl_o.is_jump = 1'b1;
            default: ;
        endcase

        if (op_i inside {OP_CMPM, OP_LD, OP_ADDM, OP_NORM}) begin
            ctrl_o.operand_sel = 1'b1;
            ctrl_o.not_oe_ram  = 1'b0;
        end
    end

endmodule

// File: rtl/nibbler_control.sv
// Nibbler fetch/decode/execute sequencer: owns PC, IR, the second address byte,
// the carry/zero flag registers and the three-state instruction FSM.
module nibbler_control
    import nibbler_pkg::*;
#(
    parameter int ADDR_W = 12
) (
    input  logic               clk,
    input  logic               notReset,
    nibbler_control_if.master  bus
);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [7:0]        ir_q, ir_d;
    logic [7:0]        addr_lo_q, addr_lo_d;
    logic              carry_q, carry_d;
    logic              zero_q, zero_d;

    opcode_t           dec_op;
    ctrl_t             ctrl;
    logic              exec;
    logic              jump_taken;
    logic [ADDR_W-1:0] target;

    // In FETCH the decoder sees the byte arriving from ROM so its length is known
    // before IR is written; afterwards it sees the latched opcode.
    assign dec_op = (state_q == FETCH) ? opcode_t'(bus.romData[7:4]) : opcode_t'(ir_q[7:4]);

    nibbler_decode u_decode (
        .op_i   (dec_op),
        .ctrl_o (ctrl)
    );

    assign exec   = (state_q == EXECUTE);
    assign target = ADDR_W'({ir_q[3:0], addr_lo_q});

    always_comb begin
        case (opcode_t'(ir_q[7:4]))
            OP_JMP:  jump_taken = 1'b1;
            OP_JC:   jump_taken = ~carry_q;
            OP_JNC:  jump_taken = carry_q;
            OP_JZ:   jump_taken = ~zero_q;
            OP_JNZ:  jump_taken = zero_q;
            default: jump_taken = 1'b0;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        ir_d      = ir_q;
        addr_lo_d = addr_lo_q;
        carry_d   = carry_q;
        zero_d    = zero_q;

        case (state_q)
            FETCH: begin
                ir_d    = bus.romData;
                pc_d    = pc_q + 1'b1;
                state_d = ctrl.two_byte ? FETCH2 : EXECUTE;
            end
            FETCH2: begin
                addr_lo_d = bus.romData;
                pc_d      = pc_q + 1'b1;
                state_d   = EXECUTE;
            end
            EXECUTE: begin
                state_d = FETCH;
                if (ctrl.updates_flags) begin
                    carry_d = bus.notC;
                    zero_d  = bus.notZ;
                end
                if (ctrl.is_jump && jump_taken) begin
                    pc_d = target;
                end
            end
            default: state_d = FETCH;
        endcase
    end

    always_ff @(posedge clk or negedge notReset) begin
        if (!notReset) begin
            state_q   <= FETCH;
            pc_q      <= '0;
            ir_q      <= '0;
            addr_lo_q <= '0;
            carry_q   <= 1'b1;
            zero_q    <= 1'b1;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            ir_q      <= ir_d;
            addr_lo_q <= addr_lo_d;
            carry_q   <= carry_d;
            zero_q    <= zero_d;
        end
    end

    assign bus.romAddr    = pc_q;
    assign bus.immediate  = ir_q[3:0];
    assign bus.ramAddr    = target;

    // Strobes are forced inactive outside EXECUTE, so reset releases them at once.
    assign bus.operandSel = exec & ctrl.operand_sel;
    assign bus.notOeRam   = ~exec | ctrl.not_oe_ram;
    assign bus.notWeRam   = ~exec | ctrl.not_we_ram;
    assign bus.notOeALU   = ~exec | ctrl.not_oe_alu;
    assign bus.notLoadA   = ~exec | ctrl.not_load_a;
    assign bus.notOeIn    = ~exec | ctrl.not_oe_in;
    assign bus.notLoadOut = ~exec | ctrl.not_load_out;
    assign {bus.notCarryIn, bus.aluS} = exec ? ctrl.alu_mode : ALU_PASS;

    assign bus.dbgState   = state_q;
    assign bus.dbgCarry   = carry_q;
    assign bus.dbgZero    = zero_q;

endmodule
